byte_ram_arbiter: RTL and testbench
===================================

// Module: byte_ram_arbiter
// PURPOSE
//  Shares the single-port byte RAM between two requesters: port 0 (CPU pipeline
//  operand fetch/store) and port 1 (peripheral/DMA side). Arbitrates round-robin,
//  sequences each access into the RAM enable/rw/address/data pins, captures read
//  data and returns it with a per-port valid pulse. Sits between requesters and byteRam.
// PARAMETERS
//  DATA_W   8   byte RAM data width
//  ADDR_W   8   byte RAM address width
// PORTS
//  clk          in   1       system clock; all logic on posedge
//  reset        in   1       synchronous, active-high reset
//  req0/req1    in   1       access request; held high with fields stable until gnt
//  rw0/rw1      in   1       1 = read, 0 = write (byteRam encoding)
//  addr0/addr1  in   ADDR_W  access address
//  wdata0/wdata1 in  DATA_W  write data
//  gnt0/gnt1    out  1       one-cycle pulse: request accepted and issued to RAM
//  rvalid0/rvalid1 out 1     one-cycle pulse: rdata holds this port's read result
//  rdata        out  DATA_W  shared read data; qualified only by rvalidN
//  busy         out  1       high whenever FSM is not IDLE
//  ramEn        out  1       to byteRamEn
//  ramRw        out  1       to byteRamRw
//  ramAddr      out  ADDR_W  to byteRamAddr
//  ramWdata     out  DATA_W  to byteRamIn
//  ramRdata     in   DATA_W  from byteRamOut (valid only in cycle after a read edge)
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE; gnt*, rvalid*, ramEn, busy = 0;
//    ramRw=1; ramAddr, ramWdata, rdata = 0; lastGnt=1 (port 0 wins first tie).
//  - FSM IDLE -> ISSUE -> (read) CAPT -> IDLE; (write) ISSUE -> IDLE.
//  - IDLE: req sampled at edge E0. One requester: it wins. Both: winner = port
//    not equal to lastGnt. Winner's rw/addr/wdata latched, owner and lastGnt
//    updated, go ISSUE. No request: stay IDLE, ramEn=0.
//  - ISSUE (cycle after E0): ramEn=1, ram* = latched fields, gntOwner=1 for this
//    cycle only. RAM performs access at edge E1. Requests ignored in ISSUE/CAPT.
//  - Write: at E1 -> IDLE, ramEn=0. Write occupancy 2 cycles, no rvalid.
//  - Read: at E1 -> CAPT, ramEn=0. At E2 rdata <= ramRdata, rvalidOwner=1 for
//    the following cycle; -> IDLE. Read latency req-sampled to rvalid = 3 edges.
//  - ramEn=0 in CAPT makes byteRam tri-state its output at E2; capture at E2
//    samples the pre-edge value, so data is correct.
//  - rdata holds last captured value until next read capture.
//  - Requester must drop/change req no earlier than the edge ending its gnt
//    cycle; a req still high in the next IDLE is treated as a new request.
//  - Fairness: with both reqs continuously high, grants strictly alternate.
//  - Reset mid-operation: in-flight access abandoned, no gnt/rvalid issued after
//    reset edge, ramEn forced 0 the cycle after reset asserts; lastGnt back to 1.
//  - gnt0 & gnt1 never high together; rvalid0 & rvalid1 never high together.
// TESTING
//  - Reset: hold reset 2 cycles -> all outputs at reset values, busy=0, ramEn=0.
//  - Port0 write addr 0x10 data 0xA5, then port0 read 0x10 -> gnt0 pulse each,
//    ramEn pulse 1 cycle, rvalid0=1 with rdata=0xA5 3 edges after read req.
//  - req0 & req1 both read (0x10, 0x20) same cycle -> port0 granted first, then
//    port1; rvalid0 then rvalid1, never overlapping; grants alternate over 6 reqs.
//  - Port1 write 0x20=0x3C during port0 read of 0x20 in flight -> port0 gets old
//    data, port1 write issues only after CAPT; later read returns 0x3C.
//  - Assert reset in CAPT of a read -> no rvalid, busy=0, next req0 granted normally.
//  - Both reqs held high 10 cycles -> gnt0/gnt1 alternate, checker sees no port starved.

Source files
------------

// File: rtl/byte_ram_arbiter.sv
// Round-robin arbiter sharing one single-port byte RAM between two requesters.
// Sequences each access onto the RAM pins and returns read data per port.
module byte_ram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_rw0,
    input  logic              i_rw1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic              o_ramEn,
    output logic              o_ramRw,
    output logic [ADDR_W-1:0] o_ramAddr,
    output logic [DATA_W-1:0] o_ramWdata,
    input  logic [DATA_W-1:0] i_ramRdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_lastGnt;
    logic                r_owner;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
    logic                r_ramEn;
    logic                r_ramRw;
    logic [ADDR_W-1:0]   r_ramAddr;
    logic [DATA_W-1:0]   r_ramWdata;

    state_t              w_state_nx;
    logic                w_lastGnt_nx;
    logic                w_owner_nx;
    logic                w_win;
    logic                w_gnt0_nx;
    logic                w_gnt1_nx;
    logic                w_rvalid0_nx;
    logic                w_rvalid1_nx;
    logic [DATA_W-1:0]   w_rdata_nx;
    logic                w_busy_nx;
    logic                w_ramEn_nx;
    logic                w_ramRw_nx;
    logic [ADDR_W-1:0]   w_ramAddr_nx;
    logic [DATA_W-1:0]   w_ramWdata_nx;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nx    = r_state;
        w_lastGnt_nx  = r_lastGnt;
        w_owner_nx    = r_owner;
        w_win         = 1'b0;
        w_gnt0_nx     = 1'b0;
        w_gnt1_nx     = 1'b0;
        w_rvalid0_nx  = 1'b0;
        w_rvalid1_nx  = 1'b0;
        w_rdata_nx    = r_rdata;
        w_ramEn_nx    = 1'b0;
        w_ramRw_nx    = r_ramRw;
        w_ramAddr_nx  = r_ramAddr;
        w_ramWdata_nx = r_ramWdata;

        unique case (r_state)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    // On a tie the port that did not win last time goes next.
                    if (i_req0 && i_req1) begin
                        w_win = ~r_lastGnt;
                    end else begin
                        w_win = i_req1;
                    end
                    w_owner_nx    = w_win;
                    w_lastGnt_nx  = w_win;
                    w_gnt0_nx     = ~w_win;
                    w_gnt1_nx     = w_win;
                    w_ramEn_nx    = 1'b1;
                    w_ramRw_nx    = w_win ? i_rw1 : i_rw0;
                    w_ramAddr_nx  = w_win ? i_addr1 : i_addr0;
                    w_ramWdata_nx = w_win ? i_wdata1 : i_wdata0;
                    w_state_nx    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nx = r_ramRw ? S_CAPT : S_IDLE;
            end
            S_CAPT: begin
                // RAM output is still valid just before this edge.
                w_rdata_nx   = i_ramRdata;
                w_rvalid0_nx = ~r_owner;
                w_rvalid1_nx = r_owner;
                w_state_nx   = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_lastGnt  <= 1'b1;
            r_owner    <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_ramEn    <= 1'b0;
            r_ramRw    <= 1'b1;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_lastGnt  <= w_lastGnt_nx;
            r_owner    <= w_owner_nx;
            r_gnt0     <= w_gnt0_nx;
            r_gnt1     <= w_gnt1_nx;
            r_rvalid0  <= w_rvalid0_nx;
            r_rvalid1  <= w_rvalid1_nx;
            r_rdata    <= w_rdata_nx;
            r_busy     <= w_busy_nx;
            r_ramEn    <= w_ramEn_nx;
            r_ramRw    <= w_ramRw_nx;
            r_ramAddr  <= w_ramAddr_nx;
            r_ramWdata <= w_ramWdata_nx;
        end
    end

    assign o_gnt0     = r_gnt0;
    assign o_gnt1     = r_gnt1;
    assign o_rvalid0  = r_rvalid0;
    assign o_rvalid1  = r_rvalid1;
    assign o_rdata    = r_rdata;
    assign o_busy     = r_busy;
    assign o_ramEn    = r_ramEn;
    assign o_ramRw    = r_ramRw;
    assign o_ramAddr  = r_ramAddr;
    assign o_ramWdata = r_ramWdata;

    a_gnt_excl: assert property (@(posedge i_clk) !(r_gnt0 && r_gnt1));
    a_rv_excl:  assert property (@(posedge i_clk) !(r_rvalid0 && r_rvalid1));
    a_en_issue: assert property (@(posedge i_clk) r_ramEn |-> (r_state == S_ISSUE));

endmodule

// File: tb/tb_byte_ram_arbiter.sv
// Scoreboard bench for byte_ram_arbiter with a behavioural byte RAM.
// Directed requests push expected grants/read data; a monitor pops and compares.
module tb_byte_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, rw0, rw1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy;
    logic       ramEn, ramRw;
    logic [7:0] rdata, ramAddr, ramWdata, ramRdata;

    always #5 clk = ~clk;

    byte_ram_arbiter #(.DATA_W(8), .ADDR_W(8)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req0(req0), .i_req1(req1), .i_rw0(rw0), .i_rw1(rw1),
        .i_addr0(addr0), .i_addr1(addr1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata(rdata), .o_busy(busy),
        .o_ramEn(ramEn), .o_ramRw(ramRw),
        .o_ramAddr(ramAddr), .o_ramWdata(ramWdata),
        .i_ramRdata(ramRdata)
    );

    // Behavioural byte RAM: synchronous access, output valid the cycle after a read.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ramEn) begin
            if (ramRw) ramRdata <= mem[ramAddr];
            else       mem[ramAddr] <= ramWdata;
        end else begin
            ramRdata <= 8'h00;
        end
    end

    typedef struct packed {
        logic       port;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } gexp_t;

    gexp_t      gq[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         gcyc0 = 0;
    int         gcyc1 = 0;
    logic       prev_en = 1'b0;
    gexp_t      ge;
    logic [7:0] ed;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: compares every grant and read return against the queues.
    always @(negedge clk) begin
        cyc++;
        if (ramEn) check("ramEn_pulse", 32'(prev_en), 32'd0);
        prev_en = ramEn;
        if (gnt0 || gnt1) begin
            check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
            if (gq.size() == 0) begin
                unexpected("gnt_unexpected");
            end else begin
                ge = gq.pop_front();
                check("grant", 32'({gnt1, ramEn, ramRw, ramAddr, ramWdata}),
                      32'({ge.port, 1'b1, ge.rw, ge.addr, ge.wdata}));
            end
            if (gnt0) gcyc0 = cyc;
            if (gnt1) gcyc1 = cyc;
        end
        if (rvalid0 || rvalid1) begin
            check("rvalid_excl", 32'(rvalid0 & rvalid1), 32'd0);
            if (rvalid0) begin
                check("lat0", 32'(cyc - gcyc0), 32'd2);
                if (q0.size() == 0) unexpected("rvalid0_unexpected");
                else begin
                    ed = q0.pop_front();
                    check("rdata0", 32'(rdata), 32'(ed));
                end
            end
            if (rvalid1) begin
                check("lat1", 32'(cyc - gcyc1), 32'd2);
                if (q1.size() == 0) unexpected("rvalid1_unexpected");
                else begin
                    ed = q1.pop_front();
                    check("rdata1", 32'(rdata), 32'(ed));
                end
            end
        end
    end

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic req_one(input bit p, input logic rw, input logic [7:0] a,
                           input logic [7:0] wd);
        int  n;
        logic got;
        if (p) begin rw1 = rw; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        else   begin rw0 = rw; addr0 = a; wdata0 = wd; req0 = 1'b1; end
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = p ? gnt1 : gnt0;
        end
        check("gnt_wait", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    task automatic req_both(input int n, input logic r0, input logic [7:0] a0,
                            input logic [7:0] d0, input logic r1,
                            input logic [7:0] a1, input logic [7:0] d1,
                            output int c0, output int c1);
        int k;
        rw0 = r0; addr0 = a0; wdata0 = d0;
        rw1 = r1; addr1 = a1; wdata1 = d1;
        req0 = 1'b1;
        req1 = 1'b1;
        c0 = 0;
        c1 = 0;
        k = 0;
        while ((c0 + c1) < n && k < 200) begin
            @(negedge clk);
            k++;
            if (gnt0) c0++;
            if (gnt1) c1++;
        end
        check("both_wait", 32'(c0 + c1), 32'(n));
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        int c0, c1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b1; rw1 = 1'b1;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", 32'({gnt0, gnt1, rvalid0, rvalid1, busy, ramEn, ramRw}),
              32'b0000001);
        check("rst_ram", 32'({ramAddr, ramWdata}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        settle();

        // Port 0 write then read back
        gq.push_back(gexp_t'{1'b0, 1'b0, 8'h10, 8'hA5});
        req_one(1'b0, 1'b0, 8'h10, 8'hA5);
        settle();
        check("wr_idle", 32'({busy, ramEn}), 32'd0);
        gq.push_back(gexp_t'{1'b0, 1'b1, 8'h10, 8'h00});
        q0.push_back(8'hA5);
        req_one(1'b0, 1'b1, 8'h10, 8'h00);
        settle();
        check("rdata_hold", 32'(rdata), 32'hA5);

        // Port 1 write so port 0 wins the next tie
        gq.push_back(gexp_t'{1'b1, 1'b0, 8'h20, 8'h55});
        req_one(1'b1, 1'b0, 8'h20, 8'h55);
        settle();

        // Both read simultaneously, held for 6 grants
        for (int i = 0; i < 3; i++) begin
            gq.push_back(gexp_t'{1'b0, 1'b1, 8'h10, 8'h00});
            gq.push_back(gexp_t'{1'b1, 1'b1, 8'h20, 8'h00});
            q0.push_back(8'hA5);
            q1.push_back(8'h55);
        end
        req_both(6, 1'b1, 8'h10, 8'h00, 1'b1, 8'h20, 8'h00, c0, c1);
        check("rd_alt_c0", 32'(c0), 32'd3);
        check("rd_alt_c1", 32'(c1), 32'd3);
        settle();

        // Port 1 write arrives while port 0 read of the same byte is in flight
        gq.push_back(gexp_t'{1'b0, 1'b1, 8'h20, 8'h00});
        gq.push_back(gexp_t'{1'b1, 1'b0, 8'h20, 8'h3C});
        q0.push_back(8'h55);
        fork
            req_one(1'b0, 1'b1, 8'h20, 8'h00);
            begin
                @(posedge clk);
                #1;
                req_one(1'b1, 1'b0, 8'h20, 8'h3C);
            end
        join
        settle();
        gq.push_back(gexp_t'{1'b0, 1'b1, 8'h20, 8'h00});
        q0.push_back(8'h3C);
        req_one(1'b0, 1'b1, 8'h20, 8'h00);
        settle();

        // Reset during CAPT of a read
        gq.push_back(gexp_t'{1'b0, 1'b1, 8'h10, 8'h00});
        rw0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h00; req0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_capt", 32'({busy, ramEn, rvalid0, gnt0}), 32'd0);
        reset = 1'b0;
        settle();
        check("rst_quiet", 32'({busy, ramEn}), 32'd0);

        // lastGnt restored: port 0 wins the first tie after reset
        gq.push_back(gexp_t'{1'b0, 1'b0, 8'h40, 8'h77});
        gq.push_back(gexp_t'{1'b1, 1'b0, 8'h41, 8'h88});
        req_both(2, 1'b0, 8'h40, 8'h77, 1'b0, 8'h41, 8'h88, c0, c1);
        settle();
        gq.push_back(gexp_t'{1'b0, 1'b1, 8'h10, 8'h00});
        q0.push_back(8'hA5);
        req_one(1'b0, 1'b1, 8'h10, 8'h00);
        settle();

        // Both held: port 1 is due first, grants must alternate
        for (int i = 0; i < 3; i++) begin
            gq.push_back(gexp_t'{1'b1, 1'b0, 8'h31, 8'h22});
            gq.push_back(gexp_t'{1'b0, 1'b0, 8'h30, 8'h11});
        end
        req_both(6, 1'b0, 8'h30, 8'h11, 1'b0, 8'h31, 8'h22, c0, c1);
        check("fair", 32'(c0), 32'(c1));
        settle();
        gq.push_back(gexp_t'{1'b1, 1'b1, 8'h31, 8'h00});
        q1.push_back(8'h22);
        req_one(1'b1, 1'b1, 8'h31, 8'h00);
        settle();
        gq.push_back(gexp_t'{1'b0, 1'b1, 8'h30, 8'h00});
        q0.push_back(8'h11);
        req_one(1'b0, 1'b1, 8'h30, 8'h00);
        settle();

        check("gq_empty", 32'(gq.size()), 32'd0);
        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
